// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: converts a simple command/response
// handshake into AXI-Lite write (AW+W+B) or read (AR+R) transactions.
module axil_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                busy,
  output logic                timeout_err,
  output logic [31:0]         wr_count,
  output logic [31:0]         rd_count
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_done, w_done;
  logic [CW-1:0]     wait_cnt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting;

  assign cmd_ready = rstn && (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE);
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = '1;

  always_comb begin
    aw_hs   = m_awvalid && m_awready;
    w_hs    = m_wvalid && m_wready;
    b_hs    = m_bvalid && m_bready;
    ar_hs   = m_arvalid && m_arready;
    r_hs    = m_rvalid && m_rready;
    any_hs  = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    waiting = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      wr_count    <= '0;
      rd_count    <= '0;
    end else begin
      // Every state change out of a waiting state coincides with a handshake,
      // so clearing on handshake also covers "clear on entry".
      if (!waiting || any_hs) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TMO) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == TMO_M1) timeout_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR;
            end else begin
              m_arvalid <= 1'b1;
              state     <= RD_A;
            end
          end
        end
        WR: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_bready <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_resp  <= m_bresp;
            rsp_rdata <= '0;
            rsp_write <= 1'b1;
            state     <= RSP;
          end
        end
        RD_A: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_R;
          end
        end
        RD_R: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_rdata <= m_rdata;
            rsp_resp  <= m_rresp;
            rsp_write <= 1'b0;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            if (rsp_write) wr_count <= wr_count + 32'd1;
            else           rd_count <= rd_count + 32'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
